// File: rtl/cmpxchg_mem_seq.sv
// Memory-side sequencer for CMPXCHG r/m32 with a memory destination: locked read, compare, locked write, writeback.
// Optional macro CMPXCHG_FULL_FLAGS_EN: produce all six CMP-style flags; otherwise only ZF is produced.

module cmpxchg_mem_seq #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_src,
    input  logic [31:0]       in_eax,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_lock,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_eax,
    output logic              wb_eax_we,
    output logic [5:0]        wb_flags,
    output logic [5:0]        wb_flags_mask
);

    // state   | meaning
    // ST_IDLE | waiting for an op from execute
    // ST_RD   | locked read of the destination outstanding
    // ST_WR   | locked write-back outstanding (always written, x86 semantics)
    // ST_DONE | result presented to writeback
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_src;
    logic [31:0]       r_eax;
    logic [31:0]       r_dest;
    logic              r_eq;
    logic [5:0]        r_flags;

    logic              w_eq;
    logic [5:0]        w_flags;

    assign w_eq = (r_eax == mem_rdata);

`ifdef CMPXCHG_FULL_FLAGS_EN
    logic [32:0] w_diff;
    logic [4:0]  w_diff_lo;
    logic        w_of;

    assign w_diff    = {1'b0, r_eax} - {1'b0, mem_rdata};
    assign w_diff_lo = {1'b0, r_eax[3:0]} - {1'b0, mem_rdata[3:0]};
    assign w_of      = (r_eax[31] ^ mem_rdata[31]) & (r_eax[31] ^ w_diff[31]);
    // {OF, SF, ZF, AF, PF, CF}
    assign w_flags       = {w_of, w_diff[31], w_eq, w_diff_lo[4], ~^w_diff[7:0], w_diff[32]};
    assign wb_flags_mask = 6'b111111;
`else
    assign w_flags       = {2'b00, w_eq, 3'b000};
    assign wb_flags_mask = 6'b001000;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_src   <= '0;
            r_eax   <= '0;
            r_dest  <= '0;
            r_eq    <= 1'b0;
            r_flags <= '0;
        end else begin
            if (r_state == ST_IDLE && in_valid) begin
                r_addr <= in_addr;
                r_src  <= in_src;
                r_eax  <= in_eax;
            end
            if (r_state == ST_RD && mem_ack) begin
                r_dest  <= mem_rdata;
                r_eq    <= w_eq;
                r_flags <= w_flags;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_lock    = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        wb_valid    = 1'b0;
        wb_eax      = '0;
        wb_eax_we   = 1'b0;
        wb_flags    = '0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                mem_req  = 1'b1;
                mem_lock = 1'b1;
                mem_addr = r_addr;
                if (mem_ack) begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_lock  = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = r_eq ? r_src : r_dest;
                if (mem_ack) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                wb_valid  = 1'b1;
                wb_eax    = r_eq ? r_eax : r_dest;
                wb_eax_we = ~r_eq;
                wb_flags  = r_flags;
                if (wb_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cmpxchg_mem_seq.sv
// Directed self-checking bench for cmpxchg_mem_seq; expected flags follow CMPXCHG_FULL_FLAGS_EN.

module tb_cmpxchg_mem_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_src;
    logic [31:0] in_eax;
    logic        mem_req;
    logic        mem_we;
    logic        mem_lock;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_eax;
    logic        wb_eax_we;
    logic [5:0]  wb_flags;
    logic [5:0]  wb_flags_mask;

    int n_checks = 0;
    int n_errors = 0;

`ifdef CMPXCHG_FULL_FLAGS_EN
    localparam logic [5:0] MASK_EXP   = 6'b111111;
    localparam logic [5:0] FL_EQ      = 6'b001010;
    localparam logic [5:0] FL_7M5     = 6'b000000;
    localparam logic [5:0] FL_0M1     = 6'b010111;
    localparam logic [5:0] FL_OVF     = 6'b110011;
`else
    localparam logic [5:0] MASK_EXP   = 6'b001000;
    localparam logic [5:0] FL_EQ      = 6'b001000;
    localparam logic [5:0] FL_7M5     = 6'b000000;
    localparam logic [5:0] FL_0M1     = 6'b000000;
    localparam logic [5:0] FL_OVF     = 6'b000000;
`endif

    cmpxchg_mem_seq #(.ADDR_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_src        (in_src),
        .in_eax        (in_eax),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_lock      (mem_lock),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_eax        (wb_eax),
        .wb_eax_we     (wb_eax_we),
        .wb_flags      (wb_flags),
        .wb_flags_mask (wb_flags_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " mem_req"},  32'(mem_req),  32'd0);
        check({tag, " mem_lock"}, 32'(mem_lock), 32'd0);
        check({tag, " wb_valid"}, 32'(wb_valid), 32'd0);
    endtask

    // One op: accept, read (rd_dly stall cycles), write (wr_dly), writeback (wb_dly).
    task automatic do_op(input string tag, input logic [31:0] addr, input logic [31:0] src,
                         input logic [31:0] eax, input logic [31:0] memval,
                         input int rd_dly, input int wr_dly, input int wb_dly,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_eax,
                         input logic exp_we, input logic [5:0] exp_flags);
        @(posedge clk); #1;
        in_valid = 1'b1; in_addr = addr; in_src = src; in_eax = eax;
        @(negedge clk);
        check({tag, " accept ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_addr = 32'hFFFF_FFF0; in_src = 32'h0; in_eax = 32'h0;
        for (int i = 0; i <= rd_dly; i++) begin
            @(negedge clk);
            check({tag, " rd req"},   32'(mem_req),  32'd1);
            check({tag, " rd we"},    32'(mem_we),   32'd0);
            check({tag, " rd lock"},  32'(mem_lock), 32'd1);
            check({tag, " rd addr"},  mem_addr,      addr);
            check({tag, " rd ready"}, 32'(in_ready), 32'd0);
            check({tag, " rd wbv"},   32'(wb_valid), 32'd0);
            mem_ack   = (i == rd_dly);
            mem_rdata = (i == rd_dly) ? memval : 32'hDEAD_BEEF;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        end
        for (int i = 0; i <= wr_dly; i++) begin
            @(negedge clk);
            check({tag, " wr req"},   32'(mem_req),  32'd1);
            check({tag, " wr we"},    32'(mem_we),   32'd1);
            check({tag, " wr lock"},  32'(mem_lock), 32'd1);
            check({tag, " wr addr"},  mem_addr,      addr);
            check({tag, " wr data"},  mem_wdata,     exp_wdata);
            check({tag, " wr wbv"},   32'(wb_valid), 32'd0);
            mem_ack = (i == wr_dly);
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        for (int i = 0; i <= wb_dly; i++) begin
            @(negedge clk);
            check({tag, " wb valid"}, 32'(wb_valid),      32'd1);
            check({tag, " wb eax"},   wb_eax,             exp_eax);
            check({tag, " wb we"},    32'(wb_eax_we),     32'(exp_we));
            check({tag, " wb flags"}, 32'(wb_flags),      32'(exp_flags));
            check({tag, " wb mask"},  32'(wb_flags_mask), 32'(MASK_EXP));
            check({tag, " wb ready"}, 32'(in_ready),      32'd0);
            check({tag, " wb req"},   32'(mem_req),       32'd0);
            check({tag, " wb lock"},  32'(mem_lock),      32'd0);
            wb_ready = (i == wb_dly);
            // a competing op must not be taken while the result is pending
            in_valid = (i < wb_dly);
            @(posedge clk); #1;
            wb_ready = 1'b0; in_valid = 1'b0;
        end
        @(negedge clk);
        check_idle({tag, " after"});
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_addr = '0; in_src = '0; in_eax = '0;
        mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF; wb_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset mem_we",    32'(mem_we),        32'd0);
        check("reset mem_addr",  mem_addr,           32'd0);
        check("reset mem_wdata", mem_wdata,          32'd0);
        check("reset wb_eax",    wb_eax,             32'd0);
        check("reset wb_we",     32'(wb_eax_we),     32'd0);
        check("reset flags",     32'(wb_flags),      32'd0);
        check("reset mask",      32'(wb_flags_mask), 32'(MASK_EXP));
        #1 reset = 1'b1;

        // stray ack while idle must be ignored
        @(negedge clk); mem_ack = 1'b1;
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk);
        check_idle("stray ack");

        do_op("equal", 32'h0000_1000, 32'hCAFE_BABE, 32'h1234_5678, 32'h1234_5678,
              0, 0, 0, 32'hCAFE_BABE, 32'h1234_5678, 1'b0, FL_EQ);
        do_op("unequal", 32'h0000_1004, 32'h1111_1111, 32'h0000_0007, 32'h0000_0005,
              0, 0, 0, 32'h0000_0005, 32'h0000_0005, 1'b1, FL_7M5);
        do_op("borrow", 32'h0000_1008, 32'h2222_2222, 32'h0000_0000, 32'h0000_0001,
              0, 0, 0, 32'h0000_0001, 32'h0000_0001, 1'b1, FL_0M1);
        do_op("stall", 32'h0000_2000, 32'h0BAD_F00D, 32'hAAAA_5555, 32'hAAAA_5555,
              4, 2, 0, 32'h0BAD_F00D, 32'hAAAA_5555, 1'b0, FL_EQ);
        do_op("backpr", 32'h0000_3004, 32'h3333_3333, 32'h7FFF_FFFF, 32'h8000_0000,
              0, 0, 5, 32'h8000_0000, 32'h8000_0000, 1'b1, FL_OVF);

        // reset while the locked write is outstanding
        @(posedge clk); #1;
        in_valid = 1'b1; in_addr = 32'h0000_4000; in_src = 32'h4444_4444; in_eax = 32'h9;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h9;
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk);
        check("rstwr in wr", 32'(mem_we), 32'd1);
        #1 reset = 1'b0;
        #1 check_idle("rstwr async");
        @(negedge clk);
        check_idle("rstwr held");
        #1 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_idle("rstwr post");
        end

        do_op("recover", 32'h0000_1000, 32'h5555_AAAA, 32'h0000_0042, 32'h0000_0042,
              0, 0, 0, 32'h5555_AAAA, 32'h0000_0042, 1'b0, FL_EQ);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cmpxchg_mem_seq.md
Name: cmpxchg_mem_seq

Overview:
Memory-side sequencer for CMPXCHG r/m32, r32 when the destination is in memory. It accepts an issued op from execute and performs a locked read of the destination. It compares the read value with EAX, performs a locked write (SRC if equal, original value if not, per x86 always-write semantics), then returns the new EAX, an EAX write-enable and flags to writeback. It sits between the execute stage and the data-cache port.

Parameters:
ADDR_W, 32, width of the linear memory address.

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  execute presents a memory CMPXCHG op
in_ready  output  1  sequencer can accept an op (IDLE only)
in_addr  input  ADDR_W  destination address
in_src  input  32  SRC register value
in_eax  input  32  accumulator value
mem_req  output  1  memory request valid
mem_we  output  1  1 = write, 0 = read
mem_lock  output  1  bus lock; held from read request through write ack
mem_addr  output  ADDR_W  request address
mem_wdata  output  32  write data
mem_ack  input  1  request accepted/completed this cycle
mem_rdata  input  32  read data, valid when mem_ack on a read
wb_valid  output  1  result available
wb_ready  input  1  writeback consumes result
wb_eax  output  32  new EAX value
wb_eax_we  output  1  1 when compare failed (EAX <- DEST)
wb_flags  output  6  {OF,SF,AF? no: [5]OF,[4]SF,[3]ZF,[2]AF,[1]PF,[0]CF}
wb_flags_mask  output  6  which wb_flags bits are architecturally written

Behaviour:
- States: IDLE, RD, WR, DONE. All state and datapath regs are flops with async active-low clear.
- Reset values: state=IDLE; in_ready=1; mem_req=0, mem_we=0, mem_lock=0, mem_addr=0, mem_wdata=0; wb_valid=0, wb_eax=0, wb_eax_we=0, wb_flags=0.
- IDLE: in_ready=1. On in_valid&in_ready, latch addr/src/eax and go to RD. No other state accepts input.
- RD: mem_req=1, mem_we=0, mem_lock=1, mem_addr=latched addr. The request is held stable until mem_ack; ack may arrive in the first RD cycle.
  - On ack: capture dest=mem_rdata and eq=(latched eax==dest), compute flags, go to WR.
- WR: mem_req=1, mem_we=1, mem_lock=1, same addr, mem_wdata = eq ? src : dest. Held until mem_ack.
  - On ack: go to DONE; mem_lock drops in the same edge.
- DONE: mem_req=0, mem_lock=0, wb_valid=1.
  - wb_eax = eq ? latched eax : dest; wb_eax_we = ~eq.
  - Outputs are held stable until wb_ready; on wb_valid&wb_ready go to IDLE.
- Minimum latency from acceptance to wb_valid is 3 cycles (ack on the first cycle of RD and WR).
- mem_ack while mem_req=0 is ignored.
- mem_lock is never deasserted between the read and the write of one op.
- Reset asserted mid-operation returns to IDLE immediately: lock drops, the op is discarded, and no writeback occurs.
- Flags are computed from the 32-bit subtraction eax - dest.
  - ZF = (eax==dest) in all builds.
  - wb_flags[3]=ZF.

Optional Feature:
CMPXCHG_FULL_FLAGS_EN
- Defined:
  - All six flags are produced from eax - dest, as in CMP: CF=borrow out of bit 31, PF=even parity of result[7:0], AF=borrow out of bit 3, SF=result[31], OF=signed overflow.
  - wb_flags_mask=6'b111111.
- Undefined:
  - Only ZF is computed; other wb_flags bits are 0.
  - wb_flags_mask=6'b001000.

Test Plan:
- Equal case: addr=0x1000, mem holds 0x12345678, eax=0x12345678, src=0xCAFEBABE, acks same-cycle -> write 0xCAFEBABE to 0x1000; wb_eax_we=0; wb_flags[3]=1; wb_valid 3 cycles after accept.
- Unequal case: mem=0x00000005, eax=0x00000007 -> write 0x00000005 back; wb_eax=0x00000005, wb_eax_we=1, ZF=0. With macro: CF=0, SF=0, OF=0, result 2.
- Borrow/flags (macro on): eax=0x00000000, mem=0x00000001 -> CF=1, SF=1, AF=1, PF=1 (0xFF), OF=0, ZF=0, mask=0x3F.
- Ack stall: mem_ack delayed 4 cycles on read and 2 on write -> mem_req, mem_addr and mem_wdata stable throughout; mem_lock continuous from first RD cycle to WR ack.
- Writeback backpressure: wb_ready low 5 cycles -> wb_valid and outputs held, in_ready=0; accept the next op only after the handshake.
- Reset mid-WR: reset low while in WR -> next sample shows mem_req=0, mem_lock=0, wb_valid=0, in_ready=1; no wb_valid after release.
